// File: rtl/seg7_scan.sv
// ---------------------------------------------------------------------------
// seg7_scan
//
// Multiplexed 4-digit 7-segment scan driver. Four BCD digits plus per-digit
// decimal points are captured into a pending buffer on i_load and copied into
// the active buffer only at a frame boundary, so a scan never shows a mix of
// old and new digits. Each digit is lit for WAIT cycles, followed by GAP
// all-off cycles to suppress ghosting between digits.
//
// Optional feature macro: SEG7_LZ_BLANK_EN
//   defined   -> leading-zero blanking on digits 3..1 (digit 0 never blanks)
//   undefined -> every digit is decoded normally
//
// Parameters:
//   WAIT  clock cycles each digit is lit (>= 1)
//   GAP   all-off cycles after each digit (0 = no gap)
//   BITS  dwell/gap counter width, must hold max(WAIT, GAP) - 1
//
// Ports:
//   i_clk     system clock
//   i_rst     asynchronous active-low reset
//   i_digits  BCD digits, [3:0] = digit 0 (rightmost) .. [15:12] = digit 3
//   i_dp      decimal point per digit, 1 = lit
//   i_load    single-cycle strobe capturing i_digits/i_dp into pending
//   o_seg     active-low segments {dp,g,f,e,d,c,b,a}
//   o_dig     active-low one-hot digit strobe, bit k = digit k
//   o_frame   one-cycle pulse after digit 3's dwell ends
// ---------------------------------------------------------------------------
module seg7_scan #(
   parameter int WAIT = 10000,
   parameter int GAP  = 100,
   parameter int BITS = 14
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_digits,
   input  logic [3:0]  i_dp,
   input  logic        i_load,
   output logic [7:0]  o_seg,
   output logic [3:0]  o_dig,
   output logic        o_frame
);

   typedef enum logic {
      ST_SHOW = 1'b0,
      ST_GAP  = 1'b1
   } state_t;

   // Terminal counts for the dwell and gap phases. GAP_LAST is unused when
   // GAP = 0 because the SHOW phase then advances the digit directly.
   localparam logic [BITS-1:0] WAIT_LAST = BITS'(WAIT - 1);
   localparam logic [BITS-1:0] GAP_LAST  = (GAP > 0) ? BITS'(GAP - 1) : '0;

   state_t          state;
   state_t          state_nx;
   logic [1:0]      idx;
   logic [1:0]      idx_nx;
   logic [BITS-1:0] cnt;
   logic [BITS-1:0] cnt_nx;
   logic            frame_start;

   // {dp[3:0], digits[15:0]}
   logic [19:0]     pending;
   logic [19:0]     active;

   logic [3:0]      blank;
   logic [3:0]      cur_digit;
   logic            cur_dp;
   logic [6:0]      cur_seg7;
   logic [7:0]      seg_nx;
   logic [3:0]      dig_nx;
   logic            frame_nx;

   // Active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   // Next-state logic for the dwell/gap sequencer. frame_start flags the
   // edge on which the sequencer re-enters SHOW for digit 0, which is where
   // the active buffer is refreshed from pending.
   always_comb begin
      state_nx    = state;
      idx_nx      = idx;
      cnt_nx      = cnt + BITS'(1);
      frame_start = 1'b0;
      case (state)
         ST_SHOW: begin
            if (cnt == WAIT_LAST) begin
               cnt_nx = '0;
               if (GAP == 0) begin
                  idx_nx      = idx + 2'd1;
                  state_nx    = ST_SHOW;
                  frame_start = (idx == 2'd3);
               end else begin
                  state_nx = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_nx      = '0;
               idx_nx      = idx + 2'd1;
               state_nx    = ST_SHOW;
               frame_start = (idx == 2'd3);
            end
         end
         default: begin
            state_nx = ST_SHOW;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state <= ST_SHOW;
         idx   <= 2'd0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         cnt   <= cnt_nx;
      end
   end

   // Double buffer. On a cycle with both a load and a frame boundary the
   // active buffer takes the old pending value (non-blocking read), so the
   // new value waits a full frame. After reset both buffers are zero, which
   // already matches the "first SHOW loads pending" behaviour.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         pending <= '0;
         active  <= '0;
      end else begin
         if (i_load) begin
            pending <= {i_dp, i_digits};
         end
         if (frame_start) begin
            active <= pending;
         end
      end
   end

   // Leading-zero blanking: a digit blanks only if it and every higher digit
   // are zero, hence the chain from digit 3 downward.
`ifdef SEG7_LZ_BLANK_EN
   always_comb begin
      blank    = 4'b0000;
      blank[3] = (active[15:12] == 4'd0);
      blank[2] = blank[3] && (active[11:8] == 4'd0);
      blank[1] = blank[2] && (active[7:4] == 4'd0);
   end
`else
   assign blank = 4'b0000;
`endif

   // Output value for the current sequencer state; registered below so the
   // pins are glitch-free and reflect the previous cycle's state.
   always_comb begin
      cur_digit = active[{idx, 2'b00} +: 4];
      cur_dp    = active[16 + {3'd0, idx}];
      cur_seg7  = blank[idx] ? 7'h7F : decode(cur_digit);
      seg_nx    = 8'hFF;
      dig_nx    = 4'hF;
      frame_nx  = 1'b0;
      if (state == ST_SHOW) begin
         seg_nx   = {~cur_dp, cur_seg7};
         dig_nx   = ~(4'b0001 << idx);
         frame_nx = (idx == 2'd3) && (cnt == WAIT_LAST);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_seg   <= 8'hFF;
         o_dig   <= 4'hF;
         o_frame <= 1'b0;
      end else begin
         o_seg   <= seg_nx;
         o_dig   <= dig_nx;
         o_frame <= frame_nx;
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan
//
// Drives two seg7_scan instances from the same inputs: one with WAIT=10,
// GAP=2 (frame of 48 cycles) and one with WAIT=10, GAP=0 (frame of 40).
// A cycle-count model derives the expected outputs of both from the frame
// arithmetic; a handful of literal checks pin down the model itself.
// ---------------------------------------------------------------------------
module tb_seg7_scan;

   localparam int WAITV = 10;
   localparam int BITSV = 4;

   logic        clk;
   logic        rstN;
   logic [15:0] digits;
   logic [3:0]  dp;
   logic        load;
   logic [7:0]  seg;
   logic [3:0]  dig;
   logic        frame;
   logic [7:0]  seg0;
   logic [3:0]  dig0;
   logic        frame0;

   int errors;
   int checks;
   int cycleNo;

   logic [19:0] pend;
   logic [19:0] act   [2];
   logic [7:0]  expSeg[2];
   logic [3:0]  expDig[2];
   logic        expFr [2];

   seg7_scan #(.WAIT(WAITV), .GAP(2), .BITS(BITSV)) dut (
      .i_clk(clk), .i_rst(rstN), .i_digits(digits), .i_dp(dp), .i_load(load),
      .o_seg(seg), .o_dig(dig), .o_frame(frame)
   );

   seg7_scan #(.WAIT(WAITV), .GAP(0), .BITS(BITSV)) dutNoGap (
      .i_clk(clk), .i_rst(rstN), .i_digits(digits), .i_dp(dp), .i_load(load),
      .o_seg(seg0), .o_dig(dig0), .o_frame(frame0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int gapOf(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   // Expected segment byte for digit k of a {dp,digits} word.
   function automatic logic [7:0] segFor(input logic [19:0] v, input int k);
      logic [3:0] d;
      logic [6:0] s;
      logic       bl;
      d = v[k*4 +: 4];
      case (d)
         4'd0: s = 7'h40;  4'd1: s = 7'h79;  4'd2: s = 7'h24;
         4'd3: s = 7'h30;  4'd4: s = 7'h19;  4'd5: s = 7'h12;
         4'd6: s = 7'h02;  4'd7: s = 7'h78;  4'd8: s = 7'h00;
         4'd9: s = 7'h10;  default: s = 7'h3F;
      endcase
      bl = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
      bl = (k > 0) && ((v[15:0] >> (4 * k)) == 16'h0000);
`endif
      if (bl) s = 7'h7F;
      return {~v[16 + k], s};
   endfunction

   // Model: edge n (counted from reset release) registers the state that
   // held during cycle m = n-1. Within a frame of 4*P cycles, digit = r/P and
   // the digit is lit while r%P < WAIT. Active content changes on edges that
   // are multiples of the frame length, taking pending as it was before.
   always @(posedge clk) begin
      if (!rstN) begin
         cycleNo = 0;
         pend    = '0;
         for (int d = 0; d < 2; d++) begin
            act[d]    = '0;
            expSeg[d] = 8'hFF;
            expDig[d] = 4'hF;
            expFr[d]  = 1'b0;
         end
      end else begin
         cycleNo++;
         for (int d = 0; d < 2; d++) begin
            int p;
            int fl;
            int r;
            int k;
            p  = WAITV + gapOf(d);
            fl = 4 * p;
            r  = (cycleNo - 1) % fl;
            k  = r / p;
            if ((r % p) < WAITV) begin
               expSeg[d] = segFor(act[d], k);
               expDig[d] = ~(4'b0001 << k);
            end else begin
               expSeg[d] = 8'hFF;
               expDig[d] = 4'hF;
            end
            expFr[d] = (r == 3 * p + WAITV - 1);
            if (cycleNo % fl == 0) act[d] = pend;
         end
         if (load) pend = {dp, digits};
      end
   end

   task automatic checkOutput(input string what, input logic [7:0] got,
                              input logic [7:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got=%h want=%h (edge %0d, t=%0t)",
                  what, got, want, cycleNo, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rstN) begin
         checkOutput("rst seg", seg, 8'hFF);
         checkOutput("rst dig", {4'h0, dig}, 8'h0F);
         checkOutput("rst frame", {7'h0, frame}, 8'h00);
         checkOutput("rst seg nogap", seg0, 8'hFF);
         checkOutput("rst dig nogap", {4'h0, dig0}, 8'h0F);
      end else begin
         checkOutput("model seg", seg, expSeg[0]);
         checkOutput("model dig", {4'h0, dig}, {4'h0, expDig[0]});
         checkOutput("model frame", {7'h0, frame}, {7'h0, expFr[0]});
         checkOutput("model seg nogap", seg0, expSeg[1]);
         checkOutput("model dig nogap", {4'h0, dig0}, {4'h0, expDig[1]});
         checkOutput("model frame nogap", {7'h0, frame0}, {7'h0, expFr[1]});
      end
   end

   // Advance to 1 time unit after edge e (bounded).
   task automatic stepTo(input int e);
      int guard;
      guard = 0;
      while (cycleNo < e && guard < 20000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (cycleNo < e) begin
         errors++;
         $display("[TB] FAIL stepTo timeout: got edge %0d want %0d", cycleNo, e);
      end
   endtask

   // Present a load so that it is captured on edge e.
   task automatic applyStimulus(input int e, input logic [15:0] dv,
                                input logic [3:0] pv);
      stepTo(e - 1);
      digits = dv;
      dp     = pv;
      load   = 1'b1;
      @(posedge clk);
      #1;
      load   = 1'b0;
   endtask

   initial begin
      logic [7:0] blankOrZero;
      int         g;
      errors = 0;
      checks = 0;
      digits = '0;
      dp     = '0;
      load   = 1'b0;
      rstN   = 1'b1;
      #1 rstN = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
      blankOrZero = 8'hFF;
`else
      blankOrZero = 8'hC0;
`endif

      repeat (3) @(posedge clk);
      #1;
      checkOutput("hold seg", seg, 8'hFF);
      checkOutput("hold dig", {4'h0, dig}, 8'h0F);
      @(negedge clk);
      #1 rstN = 1'b1;

      stepTo(1);
      checkOutput("first lit seg", seg, 8'hC0);
      checkOutput("first lit dig", {4'h0, dig}, 8'h0E);
      checkOutput("first lit frame", {7'h0, frame}, 8'h00);
      stepTo(10);
      checkOutput("last lit dig", {4'h0, dig}, 8'h0E);
      stepTo(11);
      checkOutput("gap seg", seg, 8'hFF);
      checkOutput("gap dig", {4'h0, dig}, 8'h0F);
      checkOutput("nogap step dig", {4'h0, dig0}, 8'h0D);
      stepTo(40);
      checkOutput("nogap frame", {7'h0, frame0}, 8'h01);
      stepTo(46);
      checkOutput("frame pulse", {7'h0, frame}, 8'h01);
      stepTo(47);
      checkOutput("frame one cycle", {7'h0, frame}, 8'h00);

      // Mid-frame load: current frame keeps showing the old digits.
      applyStimulus(60, 16'h0042, 4'b0001);
      stepTo(61);
      checkOutput("old frame d1", seg, 8'hC0);
      checkOutput("old frame dig", {4'h0, dig}, 8'h0D);
      stepTo(97);
      checkOutput("0042 d0", seg, 8'h24);
      stepTo(109);
      checkOutput("0042 d1", seg, 8'h99);
      stepTo(121);
      checkOutput("0042 d2", seg, blankOrZero);

      // Load landing exactly on the frame boundary edge.
      applyStimulus(144, 16'hFA09, 4'b0000);
      stepTo(145);
      checkOutput("boundary load old", seg, 8'h24);
      stepTo(193);
      checkOutput("FA09 d0", seg, 8'h90);
      stepTo(205);
      checkOutput("FA09 d1", seg, 8'hC0);
      stepTo(217);
      checkOutput("FA09 d2", seg, 8'hBF);
      stepTo(229);
      checkOutput("FA09 d3", seg, 8'hBF);

      applyStimulus(250, 16'h0000, 4'b0000);
      stepTo(289);
      checkOutput("0000 d0", seg, 8'hC0);
      stepTo(301);
      checkOutput("0000 d1", seg, blankOrZero);

      // Randomized loads, including back-to-back bursts.
      for (int i = 0; i < 40; i++) begin
         int burst;
         stepTo(cycleNo + $urandom_range(1, 40));
         burst = $urandom_range(1, 2);
         load  = 1'b1;
         for (int b = 0; b < burst; b++) begin
            digits = 16'($urandom);
            if ($urandom_range(0, 2) == 0) digits = digits & 16'h00FF;
            if ($urandom_range(0, 4) == 0) digits = digits & 16'h000F;
            dp = 4'($urandom);
            @(posedge clk);
            #1;
         end
         load = 1'b0;
      end

      // Asynchronous reset while a digit is lit.
      g = 0;
      while (dig == 4'hF && g < 50) begin
         @(posedge clk);
         #1;
         g++;
      end
      @(negedge clk);
      #2 rstN = 1'b0;
      #1;
      checkOutput("async rst seg", seg, 8'hFF);
      checkOutput("async rst dig", {4'h0, dig}, 8'h0F);
      checkOutput("async rst frame", {7'h0, frame}, 8'h00);
      checkOutput("async rst dig nogap", {4'h0, dig0}, 8'h0F);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 rstN = 1'b1;
      stepTo(1);
      checkOutput("post rst seg", seg, 8'hC0);
      checkOutput("post rst dig", {4'h0, dig}, 8'h0E);
      stepTo(120);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Multiplexed 4-digit 7-segment scan driver that sits directly downstream of the 0–99 counter. It takes four BCD digits and per-digit decimal points, double-buffers them so a frame never tears, and time-multiplexes them onto shared active-low segment lines with active-low digit strobes. A blanking gap between digits suppresses ghosting. A frame pulse reports each completed scan.

## Interface
Parameters:
- WAIT, 10000: clock cycles each digit is lit (≥1)
- GAP, 100: all-off cycles after each digit (0 = no gap)
- BITS, 14: width of the dwell/gap counter; must hold max(WAIT, GAP)−1

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-low reset
- i_digits  in  16  BCD digits; [3:0] = digit 0 (rightmost) … [15:12] = digit 3
- i_dp  in  4  decimal point per digit, 1 = lit
- i_load  in  1  single-cycle strobe: capture i_digits/i_dp into the pending buffer
- o_seg  out  8  active-low {dp,g,f,e,d,c,b,a}
- o_dig  out  4  active-low one-hot digit select; bit k = digit k
- o_frame  out  1  one-cycle pulse when digit 3's dwell ends

## Operation
- Registers: pending (16+4 bits), active (16+4 bits), digit index idx[1:0], counter cnt[BITS-1:0], state ∈ {SHOW, GAP}.
- Reset: pending = active = 0, idx = 0, cnt = 0, state = SHOW, o_seg = 8'hFF, o_dig = 4'hF, o_frame = 0.
- i_load high: pending ← {i_dp, i_digits}. Back-to-back loads: last one wins.
- Frame boundary (entering SHOW with idx = 0, and first SHOW after reset): active ← pending. Load and boundary in the same cycle: active takes the old pending; the new value waits for the next frame.
- SHOW: cnt counts 0…WAIT−1; at WAIT−1, cnt ← 0 and go to GAP (or, if GAP = 0, straight to SHOW with idx+1).
- GAP: cnt counts 0…GAP−1; at GAP−1, cnt ← 0, idx ← idx+1 (wraps 3→0), go to SHOW.
- o_frame asserted for the cycle after the last SHOW cycle of idx = 3.
- Decode (active-low, dp bit excluded): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Codes 10–15 show '-' (BF). The dp bit is !dp[idx].
- In SHOW, o_dig = ~(4'b0001 << idx). In GAP, o_dig = 4'hF and o_seg = 8'hFF.

## Timing
- Outputs are registered: o_seg/o_dig reflect the state/idx/active of the previous cycle, so there is 1 cycle of latency.
- Per-digit period = WAIT+GAP cycles. Frame = 4·(WAIT+GAP) cycles.
- First lit cycle after reset release is cycle 1: digit 0, with active = pending = 0.
- A value loaded at cycle t is visible at the first frame boundary after t. Worst case is one frame plus 1 cycle.
- Reset mid-frame forces all outputs off immediately (asynchronous) and discards pending.
- Exactly one o_dig bit is ever low. In GAP, none are low.

## Configuration
- SEG7_LZ_BLANK_EN defined: leading-zero blanking. A digit k ∈ {3,2,1} is blanked if it and every higher digit are 0.
  - A blanked digit gets seg = 7'h7F. Its dp bit is still driven.
  - Its strobe still fires, so timing is unchanged.
  - Digit 0 is never blanked.
- SEG7_LZ_BLANK_EN undefined: every digit is decoded normally, including leading zeros.

## Test plan
Bench settings: WAIT=10, GAP=2, BITS=4.
- Reset hold then release:
  - while i_rst=0, o_seg=FF, o_dig=F;
  - after release, digit 0 shows C0 with o_dig=E for 10 cycles, then FF/F for 2 cycles;
  - o_frame pulses every 48 cycles.
- Load 0x0042 with dp=0001 mid-frame:
  - the current frame is unchanged;
  - from the next frame, digit0 = 2 (A4 & 7F = 24) and digit1 = 4 (99);
  - digits 2 and 3 show C0 (macro off) or FF (macro on).
- i_load in the exact cycle of the frame boundary: the new value appears only one frame (48 cycles) later.
- Load 0xFA09: digit0 = 9 (90), digit1 = 0 (C0), digit2 = '-' (BF), digit3 = '-' (BF); no blanking applies even with the macro on.
- Load 0x0000 with SEG7_LZ_BLANK_EN defined: digits 3–1 show FF and digit 0 shows C0. A mid-frame reset forces FF/F within the same cycle.
- GAP=0 build: o_dig steps E→D→B→7 every 10 cycles, never shows F after reset, and o_frame pulses every 40 cycles.
